// File: rtl/mem_pkg.sv
// Opcode constants, arbiter FSM encoding and access classification shared by mem_arbiter and memory_wr.
package mem_pkg;

    localparam logic [2:0] OP_LB   = 3'b000;
    localparam logic [2:0] OP_LBU  = 3'b001;
    localparam logic [2:0] OP_LHW  = 3'b010;
    localparam logic [2:0] OP_LHWU = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SB   = 3'b101;
    localparam logic [2:0] OP_SHW  = 3'b110;
    localparam logic [2:0] OP_SW   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SHW) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [11:0] addr);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LHW, OP_LHWU, OP_SHW: bad = addr[0];
            OP_LW, OP_SW:            bad = |addr[1:0];
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory; misaligned accesses are rejected locally.
// Latency from request seen in IDLE to ack: error 1, store 2, load RD_LAT+2; requests are only sampled in IDLE.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_stall,
    output logic [2:0]  mem_opcode,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state;
    logic        ptr;
    logic        grant;
    logic [2:0]  cnt;
    logic [31:0] cap;

    logic        any_req;
    logic        gnt;
    logic [2:0]  sel_op;
    logic [11:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    assign any_req   = req0 | req1;
    assign gnt       = (req0 && req1) ? ptr : req1;
    assign sel_op    = gnt ? op1    : op0;
    assign sel_addr  = gnt ? addr1  : addr0;
    assign sel_wdata = gnt ? wdata1 : wdata0;
    assign sel_bad   = misaligned(sel_op, sel_addr);

    // cap is cleared on every grant, so stores and rejected accesses return zero.
    assign rdata0 = ack0 ? cap : 32'd0;
    assign rdata1 = ack1 ? cap : 32'd0;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            grant      <= 1'b0;
            cnt        <= 3'd0;
            cap        <= 32'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            mem_stall  <= 1'b1;
            mem_opcode <= 3'd0;
            mem_addr   <= 12'd0;
            mem_wdata  <= 32'd0;
            busy       <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            mem_stall <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant      <= gnt;
                        ptr        <= ~gnt;
                        mem_opcode <= sel_op;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        cap        <= 32'd0;
                        busy       <= 1'b1;
                        if (sel_bad) begin
                            state <= ST_RESP;
                            ack0  <= ~gnt;
                            ack1  <= gnt;
                            err0  <= ~gnt;
                            err1  <= gnt;
                        end else begin
                            state     <= ST_ISSUE;
                            mem_stall <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_store(mem_opcode)) begin
                        state <= ST_RESP;
                        ack0  <= ~grant;
                        ack1  <= grant;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= 3'(RD_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= ST_RESP;
                        cap   <= mem_rdata;
                        ack0  <= ~grant;
                        ack1  <= grant;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model; second instance covers RD_LAT=1.
module tb_mem_arbiter;

    localparam int RD_LAT = 2;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_stall;
    logic [2:0]  mem_opcode;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        req0_b, req1_b;
    logic [2:0]  op0_b, op1_b;
    logic [11:0] addr0_b, addr1_b;
    logic [31:0] wdata0_b, wdata1_b;
    logic        ack0_b, ack1_b, err0_b, err1_b;
    logic [31:0] rdata0_b, rdata1_b;
    logic        mem_stall_b;
    logic [2:0]  mem_opcode_b;
    logic [11:0] mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [31:0] mem_rdata_b;
    logic        busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .mem_stall(mem_stall),
        .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.RD_LAT(1)) dut_b (
        .CLK(CLK), .RSTn(RSTn),
        .req0(req0_b), .req1(req1_b), .op0(op0_b), .op1(op1_b),
        .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .ack0(ack0_b), .ack1(ack1_b), .err0(err0_b), .err1(err1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .mem_stall(mem_stall_b),
        .mem_opcode(mem_opcode_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    // Requester-side model: what each port currently asks for, plus the round-robin preference.
    bit          pend [2];
    logic [2:0]  m_op [2];
    logic [11:0] m_addr [2];
    logic [31:0] m_wd [2];
    bit          ptr_m;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int access_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 1;
            3'd2, 3'd3, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    task automatic drive_ports();
        req0 = pend[0]; op0 = m_op[0]; addr0 = m_addr[0]; wdata0 = m_wd[0];
        req1 = pend[1]; op1 = m_op[1]; addr1 = m_addr[1]; wdata1 = m_wd[1];
    endtask

    task automatic add_req(input int p, input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd);
        pend[p] = 1'b1; m_op[p] = op; m_addr[p] = a; m_wd[p] = wd;
    endtask

    task automatic add_rand(input int p);
        logic [11:0] a;
        a = 12'($urandom);
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        add_req(p, 3'($urandom_range(0, 7)), a, $urandom);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack0"}, ack0, 0);       chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_err0"}, err0, 0);       chk({tag, "_err1"}, err1, 0);
        chk({tag, "_rdata0"}, rdata0, 0);   chk({tag, "_rdata1"}, rdata1, 0);
        chk({tag, "_stall"}, mem_stall, 1); chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mop"}, mem_opcode, 0);  chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwd"}, mem_wdata, 0);
    endtask

    // Runs one transaction starting in an IDLE cycle; returns one cycle after the ack (next IDLE cycle).
    task automatic run_txn(input bit use_rd, input logic [31:0] rd_val);
        int          g, lat, p;
        bit          e, st;
        logic [31:0] capv, rexp;
        drive_ports();
        chk("idle_busy", busy, 0);
        chk("idle_stall", mem_stall, 1);
        g     = (pend[0] && pend[1]) ? int'(ptr_m) : (pend[1] ? 1 : 0);
        ptr_m = (g == 0);
        e     = (int'(m_addr[g]) % access_size(m_op[g])) != 0;
        st    = m_op[g] >= 3'd5;
        lat   = e ? 1 : (st ? 2 : RD_LAT + 2);
        capv  = 32'd0;
        for (int k = 1; k <= lat; k++) begin
            @(posedge CLK); #1;
            mem_rdata = (use_rd && k == RD_LAT + 1) ? rd_val : $urandom;
            if (!e && !st && k == RD_LAT + 1) capv = mem_rdata;
            chk("busy", busy, 1);
            chk("mem_stall", mem_stall, (k == 1 && !e) ? 0 : 1);
            chk("mem_opcode", mem_opcode, m_op[g]);
            chk("mem_addr", mem_addr, m_addr[g]);
            chk("mem_wdata", mem_wdata, m_wd[g]);
            for (int q = 0; q < 2; q++) begin
                p    = q;
                rexp = (k == lat && g == p) ? capv : 32'd0;
                if (p == 0) begin
                    chk("ack0", ack0, k == lat && g == 0);
                    chk("err0", err0, k == lat && g == 0 && e);
                    chk("rdata0", rdata0, rexp);
                end else begin
                    chk("ack1", ack1, k == lat && g == 1);
                    chk("err1", err1, k == lat && g == 1 && e);
                    chk("rdata1", rdata1, rexp);
                end
            end
            if ((k == 1 && $urandom_range(0, 3) == 0) || k == lat) begin
                pend[g] = 1'b0;
                drive_ports();
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic drain();
        while (pend[0] || pend[1]) run_txn(1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] capb;
        RSTn = 1'b0;
        mem_rdata = 32'd0;
        pend[0] = 1'b0; pend[1] = 1'b0; ptr_m = 1'b0;
        for (int p = 0; p < 2; p++) begin m_op[p] = 3'd0; m_addr[p] = 12'd0; m_wd[p] = 32'd0; end
        req0_b = 1'b0; req1_b = 1'b0; op0_b = 3'd0; op1_b = 3'd0;
        addr0_b = 12'd0; addr1_b = 12'd0; wdata0_b = 32'd0; wdata1_b = 32'd0; mem_rdata_b = 32'd0;

        // Contention: both ports requesting while still in reset.
        add_req(0, 3'b100, 12'h010, 32'h0);
        add_req(1, 3'b111, 12'h020, 32'hCAFE0001);
        drive_ports();
        repeat (3) @(posedge CLK);
        #1;
        check_reset("rst");
        @(posedge CLK); #1;
        RSTn = 1'b1;
        run_txn(1'b0, 32'd0);
        add_req(0, 3'b000, 12'h031, 32'h0);
        run_txn(1'b0, 32'd0);
        add_req(1, 3'b110, 12'h042, 32'hCAFE0002);
        run_txn(1'b0, 32'd0);
        drain();

        add_req(0, 3'b100, 12'h404, 32'h0);
        run_txn(1'b1, 32'hDEADBEEF);
        add_req(1, 3'b111, 12'h800, 32'h12345678);
        run_txn(1'b0, 32'd0);
        add_req(0, 3'b010, 12'h001, $urandom);
        run_txn(1'b0, 32'd0);
        add_req(1, 3'b111, 12'h802, $urandom);
        run_txn(1'b0, 32'd0);

        repeat (200) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) add_rand(0);
            if (!pend[1] && $urandom_range(0, 1) == 1) add_rand(1);
            if (!pend[0] && !pend[1]) add_rand(int'($urandom_range(0, 1)));
            run_txn(1'b0, 32'd0);
        end
        drain();

        // Reset in the middle of a load leaves the round-robin pointer back at port 0.
        add_req(0, 3'b100, 12'h100, 32'h0);
        drive_ports();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("wait_busy", busy, 1);
        pend[0] = 1'b0;
        drive_ports();
        RSTn = 1'b0;
        #1;
        check_reset("midrst");
        @(posedge CLK); #1;
        chk("midrst_noack", ack0, 0);
        RSTn  = 1'b1;
        ptr_m = 1'b0;
        add_req(0, 3'b001, 12'h205, 32'h0);
        add_req(1, 3'b101, 12'h207, 32'h000000AA);
        run_txn(1'b0, 32'd0);
        drain();

        // RD_LAT=1 instance: LB at 0xC03 acks in cycle 3.
        req0_b = 1'b1; op0_b = 3'b000; addr0_b = 12'hC03;
        capb = 32'd0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK); #1;
            mem_rdata_b = $urandom;
            if (k == 2) capb = mem_rdata_b;
            if (k == 1) req0_b = 1'b0;
            chk("b_stall", mem_stall_b, k == 1 ? 0 : 1);
            chk("b_ack0", ack0_b, k == 3);
            chk("b_err0", err0_b, 0);
            chk("b_rdata0", rdata0_b, k == 3 ? capb : 32'd0);
            chk("b_ack1", ack1_b, 0);
        end
        @(posedge CLK); #1;
        chk("b_idle_busy", busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
